// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : route_pkg
//  Description : Shared types and command encodings for the route sequencer
//                and the command processor that consumes its commands.
//  Contents    : seq_state_t  - sequencer state encoding
//                GO_PREFIX    - upper two bits of a go command
//                STOP_CMD     - stop command byte
//                go_cmd()     - builds a go command from a station ID
//  Revision    : 1.0 - initial release
// ============================================================================
package route_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        TRAVEL   = 3'd3,
        DWELL    = 3'd4,
        STOP     = 3'd5
    } seq_state_t;

    localparam logic [1:0] GO_PREFIX = 2'b01;
    localparam logic [7:0] STOP_CMD  = 8'h00;

    function automatic logic [7:0] go_cmd(input logic [5:0] id);
        return {GO_PREFIX, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : route_fifo
//  Description : DEPTH x WIDTH circular buffer holding queued station IDs.
//                Head entry is presented combinationally on o_rd_data.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_flush      - empties the buffer (beats a same-cycle write)
//                i_wr         - write i_wr_data; ignored while full
//                i_rd         - drop head entry; ignored while empty
//                o_rd_data    - current head entry
//                o_cnt        - number of stored entries
//                o_full       - o_cnt == DEPTH
//                o_empty      - o_cnt == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module route_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [$clog2(DEPTH):0] o_cnt,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full    = (r_cnt == c_DEPTH);
    assign o_empty   = (r_cnt == '0);
    assign o_cnt     = r_cnt;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_wr_en = i_wr & ~o_full;
    assign w_rd_en = i_rd & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : route_sequencer
//  Description : Issues one go command per queued station, follows the
//                command processor's in_transit flag through departure and
//                arrival, dwells at each station, and can abort with a stop.
//  Ports       : i_push/i_push_id    - enqueue a station ID
//                i_start             - begin the queued route (pulse)
//                i_abort             - stop command + queue flush (pulse)
//                i_clr_cmd_rdy       - command processor took o_cmd
//                i_in_transit        - command processor travelling flag
//                o_cmd/o_cmd_rdy     - command byte and its valid flag
//                o_busy, o_cur_dest  - route active, stop being served
//                o_q_cnt/full/empty  - queue occupancy
//                o_ovf, o_route_done - single-cycle event pulses
//                o_err               - sticky acknowledge timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module route_sequencer
    import route_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DWELL_CYC = 50000,
    parameter int ACK_TO    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [5:0]             i_push_id,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_clr_cmd_rdy,
    input  logic                   i_in_transit,
    output logic [7:0]             o_cmd,
    output logic                   o_cmd_rdy,
    output logic                   o_busy,
    output logic [5:0]             o_cur_dest,
    output logic [$clog2(DEPTH):0] o_q_cnt,
    output logic                   o_q_full,
    output logic                   o_q_empty,
    output logic                   o_ovf,
    output logic                   o_route_done,
    output logic                   o_err
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int KW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [KW-1:0] c_ACK_LAST   = KW'(ACK_TO - 1);

    seq_state_t    r_state,      w_state_nxt;
    logic [7:0]    r_cmd,        w_cmd_nxt;
    logic          r_cmd_rdy,    w_cmd_rdy_nxt;
    logic [5:0]    r_cur_dest,   w_cur_dest_nxt;
    logic [KW-1:0] r_ack_cnt,    w_ack_cnt_nxt;
    logic [DW-1:0] r_dwell_cnt,  w_dwell_cnt_nxt;
    logic          r_err,        w_err_nxt;
    logic          r_route_done, w_route_done_nxt;
    logic          r_ovf;
    logic          r_transit_d;

    logic          w_transit_fall;
    logic          w_pop;
    logic          w_flush;
    logic          w_fifo_wr;
    logic [5:0]    w_head;
    logic          w_q_full;
    logic          w_q_empty;

    // A push landing in the abort cycle is discarded along with the queue.
    assign w_fifo_wr      = i_push & ~w_flush;
    assign w_transit_fall = r_transit_d & ~i_in_transit;

    route_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (6)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_wr      (w_fifo_wr),
        .i_wr_data (i_push_id),
        .i_rd      (w_pop),
        .o_rd_data (w_head),
        .o_cnt     (o_q_cnt),
        .o_full    (w_q_full),
        .o_empty   (w_q_empty)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_nxt        = r_cmd;
        w_cmd_rdy_nxt    = r_cmd_rdy;
        w_cur_dest_nxt   = r_cur_dest;
        w_ack_cnt_nxt    = r_ack_cnt;
        w_dwell_cnt_nxt  = r_dwell_cnt;
        w_err_nxt        = r_err;
        w_route_done_nxt = 1'b0;
        w_pop            = 1'b0;
        w_flush          = 1'b0;

        if (i_abort && (r_state != IDLE) && (r_state != STOP)) begin
            // Any pending go is overwritten by the stop in the same flop.
            w_flush       = 1'b1;
            w_state_nxt   = STOP;
            w_cmd_nxt     = STOP_CMD;
            w_cmd_rdy_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && !w_q_empty) begin
                        w_pop          = 1'b1;
                        w_cur_dest_nxt = w_head;
                        w_cmd_nxt      = go_cmd(w_head);
                        w_cmd_rdy_nxt  = 1'b1;
                        w_err_nxt      = 1'b0;
                        w_state_nxt    = ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_clr_cmd_rdy) begin
                        w_cmd_rdy_nxt = 1'b0;
                        w_ack_cnt_nxt = '0;
                        w_state_nxt   = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (i_in_transit) begin
                        w_state_nxt = TRAVEL;
                    end else if (r_ack_cnt == c_ACK_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_ack_cnt != '1) begin
                        w_ack_cnt_nxt = r_ack_cnt + 1'b1;
                    end
                end
                TRAVEL: begin
                    if (w_transit_fall) begin
                        w_dwell_cnt_nxt = '0;
                        w_state_nxt     = DWELL;
                    end
                end
                DWELL: begin
                    if (r_dwell_cnt == c_DWELL_LAST) begin
                        if (w_q_empty) begin
                            w_route_done_nxt = 1'b1;
                            w_state_nxt      = IDLE;
                        end else begin
                            w_pop          = 1'b1;
                            w_cur_dest_nxt = w_head;
                            w_cmd_nxt      = go_cmd(w_head);
                            w_cmd_rdy_nxt  = 1'b1;
                            w_state_nxt    = ISSUE;
                        end
                    end else if (r_dwell_cnt != '1) begin
                        w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (i_clr_cmd_rdy) begin
                        w_cmd_rdy_nxt = 1'b0;
                        w_state_nxt   = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cmd        <= STOP_CMD;
            r_cmd_rdy    <= 1'b0;
            r_cur_dest   <= '0;
            r_ack_cnt    <= '0;
            r_dwell_cnt  <= '0;
            r_err        <= 1'b0;
            r_route_done <= 1'b0;
            r_ovf        <= 1'b0;
            r_transit_d  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cmd_rdy    <= w_cmd_rdy_nxt;
            r_cur_dest   <= w_cur_dest_nxt;
            r_ack_cnt    <= w_ack_cnt_nxt;
            r_dwell_cnt  <= w_dwell_cnt_nxt;
            r_err        <= w_err_nxt;
            r_route_done <= w_route_done_nxt;
            r_ovf        <= i_push & w_q_full & ~w_flush;
            r_transit_d  <= i_in_transit;
        end
    end

    assign o_cmd        = r_cmd;
    assign o_cmd_rdy    = r_cmd_rdy;
    assign o_busy       = (r_state != IDLE);
    assign o_cur_dest   = r_cur_dest;
    assign o_q_full     = w_q_full;
    assign o_q_empty    = w_q_empty;
    assign o_ovf        = r_ovf;
    assign o_route_done = r_route_done;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_route_sequencer
//  Description : Self-checking bench for route_sequencer. A queue of expected
//                station IDs stands in for the route; a behavioural command
//                processor acknowledges commands and toggles in_transit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_route_sequencer;

    localparam int DEPTH     = 8;
    localparam int DWELL_CYC = 20;
    localparam int ACK_TO    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_push;
    logic [5:0] i_push_id;
    logic       i_start;
    logic       i_abort;
    logic       i_clr_cmd_rdy;
    logic       i_in_transit;
    logic [7:0] o_cmd;
    logic       o_cmd_rdy;
    logic       o_busy;
    logic [5:0] o_cur_dest;
    logic [3:0] o_q_cnt;
    logic       o_q_full;
    logic       o_q_empty;
    logic       o_ovf;
    logic       o_route_done;
    logic       o_err;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [5:0] exp_q[$];

    route_sequencer #(
        .DEPTH     (DEPTH),
        .DWELL_CYC (DWELL_CYC),
        .ACK_TO    (ACK_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_push        (i_push),
        .i_push_id     (i_push_id),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_clr_cmd_rdy (i_clr_cmd_rdy),
        .i_in_transit  (i_in_transit),
        .o_cmd         (o_cmd),
        .o_cmd_rdy     (o_cmd_rdy),
        .o_busy        (o_busy),
        .o_cur_dest    (o_cur_dest),
        .o_q_cnt       (o_q_cnt),
        .o_q_full      (o_q_full),
        .o_q_empty     (o_q_empty),
        .o_ovf         (o_ovf),
        .o_route_done  (o_route_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_push = 1'b0; i_push_id = '0; i_start = 1'b0;
        i_abort = 1'b0; i_clr_cmd_rdy = 1'b0; i_in_transit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // One push; the model keeps it only if the queue had room.
    task automatic push_id(input logic [5:0] id);
        i_push = 1'b1; i_push_id = id;
        if (exp_q.size() < DEPTH) exp_q.push_back(id);
        tick();
        i_push = 1'b0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Plays the command processor until the sequencer goes idle, checking
    // each command against the expected-ID queue and the dwell/ack timing.
    task automatic run_route(input bit raise, input int push_travel_id,
                             input bit push_dwell, input bit abort_travel,
                             output int n_go, output int n_done, output int n_stop);
        int         budget, clr_wait, rise_wait, fall_wait, fall_edge, clr_edge, prev_cnt;
        bit         seen_rdy, aborted, travel_pushed, dwell_pushed;
        bit         check_flush, expect_same, err_seen, fin;
        logic [5:0] id;
        logic [7:0] exp_cmd;
        budget = 4000; clr_wait = -1; rise_wait = -1; fall_wait = -1;
        fall_edge = -1; clr_edge = -1; prev_cnt = 0;
        seen_rdy = 0; aborted = 0; travel_pushed = 0; dwell_pushed = 0;
        check_flush = 0; expect_same = 0; err_seen = 0; fin = 0;
        n_go = 0; n_done = 0; n_stop = 0;
        while (!fin) begin
            if (check_flush) begin
                check_flush = 0;
                total++;
                if (o_q_cnt !== 4'd0 || o_cmd_rdy !== 1'b1 || o_cmd !== 8'h00) begin
                    bad++;
                    $display("FAIL abort_stop: q_cnt=%0d cmd_rdy=%0b cmd=%h, want 0 1 00",
                             o_q_cnt, o_cmd_rdy, o_cmd);
                end
            end
            if (expect_same) begin
                expect_same = 0;
                total++;
                if (o_q_cnt !== prev_cnt[3:0]) begin
                    bad++;
                    $display("FAIL push_pop_cnt: q_cnt=%0d want %0d", o_q_cnt, prev_cnt);
                end
            end
            if (o_err && !err_seen) begin
                err_seen = 1;
                total++;
                if (raise || cyc != clr_edge + ACK_TO) begin
                    bad++;
                    $display("FAIL ack_timeout: err at cycle %0d, want %0d (timeout expected=%0b)",
                             cyc, clr_edge + ACK_TO, !raise);
                end
            end
            if (o_route_done) begin
                n_done++;
                total++;
                if (exp_q.size() != 0 || cyc != fall_edge + DWELL_CYC) begin
                    bad++;
                    $display("FAIL route_done: cycle %0d queued %0d, want cycle %0d queued 0",
                             cyc, exp_q.size(), fall_edge + DWELL_CYC);
                end
            end
            if (o_cmd_rdy && !seen_rdy) begin
                seen_rdy = 1;
                clr_wait = $urandom_range(0, 2);
                total++;
                if (aborted) begin
                    n_stop++;
                    if (o_cmd !== 8'h00) begin
                        bad++;
                        $display("FAIL stop_cmd: cmd=%h want 00", o_cmd);
                    end
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_go: cmd=%h with nothing queued", o_cmd);
                end else begin
                    id      = exp_q.pop_front();
                    exp_cmd = {2'b01, id};
                    n_go++;
                    if (o_cmd !== exp_cmd || o_cur_dest !== id) begin
                        bad++;
                        $display("FAIL go_cmd: cmd=%h cur_dest=%0d, want %h %0d",
                                 o_cmd, o_cur_dest, exp_cmd, id);
                    end
                    if (fall_edge >= 0) begin
                        total++;
                        if (cyc != fall_edge + DWELL_CYC) begin
                            bad++;
                            $display("FAIL dwell_time: go at cycle %0d want %0d",
                                     cyc, fall_edge + DWELL_CYC);
                        end
                    end
                end
            end
            if (!o_busy) begin
                fin = 1;
            end else begin
                i_clr_cmd_rdy = 1'b0; i_push = 1'b0; i_abort = 1'b0;
                if (clr_wait == 0) begin
                    i_clr_cmd_rdy = 1'b1;
                    clr_wait = -1;
                    seen_rdy = 0;
                    clr_edge = cyc + 1;
                    if (raise && !aborted) rise_wait = 3;
                end else if (clr_wait > 0) begin
                    clr_wait--;
                end
                if (fall_wait == 0) begin
                    i_in_transit = 1'b0;
                    fall_wait = -1;
                    fall_edge = cyc + 1;
                end else if (fall_wait > 0) begin
                    fall_wait--;
                    if (abort_travel && !aborted) begin
                        i_abort   = 1'b1;
                        i_push    = 1'b1;
                        i_push_id = 6'($urandom_range(0, 63));
                        aborted   = 1;
                        exp_q.delete();
                        check_flush = 1;
                    end else if (push_travel_id >= 0 && !travel_pushed && !aborted &&
                                 exp_q.size() == 0) begin
                        i_push    = 1'b1;
                        i_push_id = 6'(push_travel_id);
                        exp_q.push_back(6'(push_travel_id));
                        travel_pushed = 1;
                    end
                end
                if (rise_wait == 0) begin
                    i_in_transit = 1'b1;
                    rise_wait = -1;
                    fall_wait = $urandom_range(5, 30);
                end else if (rise_wait > 0) begin
                    rise_wait--;
                end
                if (push_dwell && !dwell_pushed && fall_edge >= 0 &&
                    cyc + 1 == fall_edge + DWELL_CYC && exp_q.size() != 0 && !i_push) begin
                    i_push    = 1'b1;
                    i_push_id = 6'($urandom_range(0, 63));
                    if (exp_q.size() < DEPTH) exp_q.push_back(i_push_id);
                    prev_cnt     = int'(o_q_cnt);
                    expect_same  = 1;
                    dwell_pushed = 1;
                end
                tick();
                budget--;
                if (budget == 0) begin
                    total++;
                    bad++;
                    $display("FAIL route_timeout: busy=%0b after 4000 cycles, want 0", o_busy);
                    fin = 1;
                end
            end
        end
        i_clr_cmd_rdy = 1'b0; i_push = 1'b0; i_abort = 1'b0; i_in_transit = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (o_cmd !== 8'h00 || o_cmd_rdy !== 1'b0 || o_busy !== 1'b0 || o_cur_dest !== 6'd0 ||
            o_q_cnt !== 4'd0 || o_q_full !== 1'b0 || o_q_empty !== 1'b1 || o_ovf !== 1'b0 ||
            o_route_done !== 1'b0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cmd=%h rdy=%0b busy=%0b dest=%0d cnt=%0d full=%0b empty=%0b ovf=%0b done=%0b err=%0b, want 00 0 0 0 0 0 1 0 0 0",
                     o_cmd, o_cmd_rdy, o_busy, o_cur_dest, o_q_cnt, o_q_full, o_q_empty,
                     o_ovf, o_route_done, o_err);
        end
    endtask

    task automatic test_basic_route();
        int n_go, n_done, n_stop;
        do_reset();
        push_id(6'd5); push_id(6'd9); push_id(6'd12);
        start_pulse();
        run_route(1, -1, 0, 0, n_go, n_done, n_stop);
        total++;
        if (n_go != 3 || n_done != 1 || o_q_empty !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_route: go=%0d done=%0d empty=%0b busy=%0b, want 3 1 1 0",
                     n_go, n_done, o_q_empty, o_busy);
        end
    endtask

    task automatic test_overflow();
        int n_go, n_done, n_stop;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_id(6'($urandom_range(0, 63)));
        total++;
        if (o_q_full !== 1'b1 || o_q_cnt !== 4'd8 || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL fill: full=%0b cnt=%0d ovf=%0b, want 1 8 0", o_q_full, o_q_cnt, o_ovf);
        end
        push_id(6'($urandom_range(0, 63)));
        total++;
        if (o_ovf !== 1'b1 || o_q_cnt !== 4'd8) begin
            bad++;
            $display("FAIL ovf_pulse: ovf=%0b cnt=%0d, want 1 8", o_ovf, o_q_cnt);
        end
        tick();
        total++;
        if (o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_single: ovf=%0b want 0", o_ovf);
        end
        start_pulse();
        run_route(1, -1, 1, 0, n_go, n_done, n_stop);
        total++;
        if (n_go != DEPTH + 1 || n_done != 1 || o_q_cnt !== 4'd0) begin
            bad++;
            $display("FAIL full_route: go=%0d done=%0d cnt=%0d, want %0d 1 0",
                     n_go, n_done, o_q_cnt, DEPTH + 1);
        end
    endtask

    task automatic test_ack_timeout();
        int n_go, n_done, n_stop;
        do_reset();
        push_id(6'($urandom_range(0, 63)));
        push_id(6'($urandom_range(0, 63)));
        start_pulse();
        run_route(0, -1, 0, 0, n_go, n_done, n_stop);
        total++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_q_cnt !== 4'd1 || n_go != 1) begin
            bad++;
            $display("FAIL timeout_state: err=%0b busy=%0b cnt=%0d go=%0d, want 1 0 1 1",
                     o_err, o_busy, o_q_cnt, n_go);
        end
        start_pulse();
        total++;
        if (o_err !== 1'b0 || o_cmd_rdy !== 1'b1) begin
            bad++;
            $display("FAIL restart_clr_err: err=%0b cmd_rdy=%0b, want 0 1", o_err, o_cmd_rdy);
        end
        run_route(1, -1, 0, 0, n_go, n_done, n_stop);
        total++;
        if (n_go != 1 || n_done != 1 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL restart_route: go=%0d done=%0d err=%0b, want 1 1 0", n_go, n_done, o_err);
        end
    endtask

    task automatic test_abort();
        int n_go, n_done, n_stop;
        do_reset();
        for (int i = 0; i < 3; i++) push_id(6'($urandom_range(0, 63)));
        start_pulse();
        run_route(1, -1, 0, 1, n_go, n_done, n_stop);
        total++;
        if (n_go != 1 || n_stop != 1 || n_done != 0 || o_busy !== 1'b0 || o_q_cnt !== 4'd0) begin
            bad++;
            $display("FAIL abort_route: go=%0d stop=%0d done=%0d busy=%0b cnt=%0d, want 1 1 0 0 0",
                     n_go, n_stop, n_done, o_busy, o_q_cnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_id(6'($urandom_range(0, 63)));
        push_id(6'($urandom_range(0, 63)));
        start_pulse();
        total++;
        if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL issue_before_rst: cmd_rdy=%0b busy=%0b, want 1 1", o_cmd_rdy, o_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        total++;
        if (o_cmd !== 8'h00 || o_cmd_rdy !== 1'b0 || o_busy !== 1'b0 || o_cur_dest !== 6'd0 ||
            o_q_cnt !== 4'd0 || o_q_empty !== 1'b1 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: cmd=%h rdy=%0b busy=%0b dest=%0d cnt=%0d empty=%0b err=%0b, want 00 0 0 0 0 1 0",
                     o_cmd, o_cmd_rdy, o_busy, o_cur_dest, o_q_cnt, o_q_empty, o_err);
        end
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_busy !== 1'b0 || o_cmd_rdy !== 1'b0) begin
                bad++;
                $display("FAIL empty_start: busy=%0b cmd_rdy=%0b, want 0 0", o_busy, o_cmd_rdy);
            end
            tick();
        end
    endtask

    task automatic test_append_mid_route();
        int n_go, n_done, n_stop;
        do_reset();
        push_id(6'($urandom_range(0, 63)));
        start_pulse();
        run_route(1, int'($urandom_range(0, 63)), 0, 0, n_go, n_done, n_stop);
        total++;
        if (n_go != 2 || n_done != 1 || o_q_empty !== 1'b1) begin
            bad++;
            $display("FAIL append_route: go=%0d done=%0d empty=%0b, want 2 1 1",
                     n_go, n_done, o_q_empty);
        end
    endtask

    task automatic test_random_routes();
        int n_go, n_done, n_stop, n;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_id(6'($urandom_range(0, 63)));
            start_pulse();
            run_route(1, -1, 0, 0, n_go, n_done, n_stop);
            total++;
            if (n_go != n || n_done != 1 || o_busy !== 1'b0 || o_q_empty !== 1'b1) begin
                bad++;
                $display("FAIL random_route: go=%0d done=%0d busy=%0b empty=%0b, want %0d 1 0 1",
                         n_go, n_done, o_busy, o_q_empty, n);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_push = 1'b0; i_push_id = '0; i_start = 1'b0;
        i_abort = 1'b0; i_clr_cmd_rdy = 1'b0; i_in_transit = 1'b0;
        test_reset();
        test_basic_route();
        test_overflow();
        test_ack_timeout();
        test_abort();
        test_mid_reset();
        test_append_mid_route();
        test_random_routes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
